// File: rtl/flex_down_timer.sv
// Programmable down-counting interval timer: one-shot or periodic expiry from an internal reload register.
// Optional prescaler enabled by defining FLEX_DOWN_TIMER_PRESCALE_EN (adds prescale_val port).
module flex_down_timer #(
  parameter int unsigned NUM_CNT_BITS = 4
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
  , parameter int unsigned PRESCALE_BITS = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    start,
  input  logic                    periodic,
  input  logic                    count_enable,
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expire_flag,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    expire_q, expire_d;
  logic                    busy_q;
  logic                    tick_c;

`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] psc_q, psc_d;

  // A decrement slot opens once the prescaler has seen prescale_val+1 enabled edges.
  assign tick_c = (psc_q == prescale_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end
`else
  assign tick_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
      busy_q   <= (state_d == RUN);
    end
  end

  // Next-state: clear > load > start > decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = expire_q;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    psc_d    = psc_q;
`endif
    if (clear) begin
      state_d  = IDLE;
      count_d  = '0;
      expire_d = 1'b0;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
      psc_d    = '0;
`endif
    end else if (load) begin
      state_d  = IDLE;
      reload_d = load_val;
      count_d  = load_val;
      expire_d = 1'b0;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
      psc_d    = '0;
`endif
    end else if (start && (reload_q != '0)) begin
      state_d  = RUN;
      count_d  = reload_q;
      expire_d = 1'b0;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
      psc_d    = '0;
`endif
    end else if (state_q == RUN) begin
      expire_d = 1'b0;
      if (count_enable) begin
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
        psc_d = tick_c ? '0 : psc_q + PRESCALE_BITS'(1);
`endif
        if (tick_c) begin
          // Count of 0 in RUN is unreachable; treating it like 1 keeps the count from wrapping.
          if (count_q > NUM_CNT_BITS'(1)) begin
            count_d = count_q - NUM_CNT_BITS'(1);
          end else if (periodic) begin
            count_d  = reload_q;
            expire_d = 1'b1;
          end else begin
            count_d  = '0;
            expire_d = 1'b1;
            state_d  = DONE;
          end
        end
      end
    end
  end

  assign count_out   = count_q;
  assign expire_flag = expire_q;
  assign busy        = busy_q;

endmodule
